unified_memory_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between the core's instruction-fetch port (requester 0) and data port (requester 1).
- Enables a von Neumann build of the RV32I core in which both fetch and load/store go through one memory.
- Round-robin arbitration with one outstanding transaction; valid/ready request channel and a response-valid pulse per requester.
- Core stall logic is driven from the req_ready/resp_valid handshakes.

---
 rtl/unified_memory_arbiter_pkg.sv | 29 ++
 rtl/unified_memory_arbiter_if.sv | 56 +++++
 rtl/unified_memory_arbiter_rr_arbiter2.sv | 44 ++++
 rtl/unified_memory_arbiter.sv | 157 +++++++++++++++
 tb/tb_unified_memory_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unified_memory_arbiter_pkg
// Description : Shared types for the unified instruction/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package unified_memory_arbiter_pkg;

  // Transaction phases of the shared memory port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Requester identity; instruction fetch is requester 0
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } requester_t;

  // The requester that did not win last time
  function automatic requester_t other_requester(requester_t r);
    return (r == REQ_IF) ? REQ_DM : REQ_IF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unified_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : unified_memory_arbiter_if
// Description : Fetch, data and memory channels of the unified arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface unified_memory_arbiter_if #(
  parameter int AddrSize   = 32,
  parameter int DataSize   = 32,
  parameter int ByteEnSize = DataSize / 8
);
  // Instruction fetch port
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [AddrSize-1:0]   if_addr;
  logic                  if_resp_valid;
  logic [DataSize-1:0]   if_resp_rdata;
  // Data port
  logic                  dm_req_valid;
  logic                  dm_req_ready;
  logic                  dm_we;
  logic [ByteEnSize-1:0] dm_be;
  logic [AddrSize-1:0]   dm_addr;
  logic [DataSize-1:0]   dm_wdata;
  logic                  dm_resp_valid;
  logic [DataSize-1:0]   dm_resp_rdata;
  // Shared memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [ByteEnSize-1:0] mem_be;
  logic [AddrSize-1:0]   mem_addr;
  logic [DataSize-1:0]   mem_wdata;
  logic                  mem_rvalid;
  logic [DataSize-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr,
    input  dm_req_valid, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_rvalid, mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_rdata,
    output dm_req_ready, dm_resp_valid, dm_resp_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Core and memory side
  modport master (
    output if_req_valid, if_addr,
    output dm_req_valid, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_rvalid, mem_rdata,
    input  if_req_ready, if_resp_valid, if_resp_rdata,
    input  dm_req_ready, dm_resp_valid, dm_resp_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/unified_memory_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : unified_memory_arbiter_rr_arbiter2
// Description : Two-way round-robin grant with last-winner memory.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_memory_arbiter_rr_arbiter2
  import unified_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output requester_t grant_idx
);

  requester_t last_grant;

  // Lone requester wins outright; on contention the previous loser wins
  always_comb begin
    grant_idx = REQ_IF;
    if (req == 2'b11) begin
      grant_idx = other_requester(last_grant);
    end else if (req[1]) begin
      grant_idx = REQ_DM;
    end
    grant = 2'b00;
    if (req != 2'b00) begin
      grant = (grant_idx == REQ_DM) ? 2'b10 : 2'b01;
    end
  end

  // Remember the winner; reset favours fetch on the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_DM;
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/unified_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_memory_arbiter
// Description : Shares one variable-latency memory between fetch and data
//               ports with round-robin arbitration, one transaction in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_memory_arbiter
  import unified_memory_arbiter_pkg::*;
#(
  parameter int AddrSize   = 32,
  parameter int DataSize   = 32,
  parameter int ByteEnSize = DataSize / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  unified_memory_arbiter_if.slave  bus,
  output logic                     err_spurious
);

  arb_state_t            state;
  arb_state_t            state_next;
  requester_t            owner;
  requester_t            grant_idx;
  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  accept;
  logic [AddrSize-1:0]   addr_q;
  logic                  we_q;
  logic [ByteEnSize-1:0] be_q;
  logic [DataSize-1:0]   wdata_q;
  logic [DataSize-1:0]   if_rdata_q;
  logic [DataSize-1:0]   dm_rdata_q;
  logic                  err_q;
  logic                  if_ready;
  logic                  dm_ready;
  logic                  if_rvalid;
  logic                  dm_rvalid;
  logic                  mem_strobe;

  assign req    = {bus.dm_req_valid, bus.if_req_valid};
  assign accept = (state == IDLE) && (req != 2'b00);

  unified_memory_arbiter_rr_arbiter2 u_rr_arbiter2 (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the handshake and strobe outputs of each phase
  always_comb begin
    state_next = state;
    if_ready   = 1'b0;
    dm_ready   = 1'b0;
    mem_strobe = 1'b0;
    if_rvalid  = 1'b0;
    dm_rvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if_ready   = grant[0];
          dm_ready   = grant[1];
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_strobe = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if_rvalid  = (owner == REQ_IF);
        dm_rvalid  = (owner == REQ_DM);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request; fetches are always full-word reads
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= REQ_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      owner <= grant_idx;
      if (grant_idx == REQ_IF) begin
        addr_q  <= bus.if_addr;
        we_q    <= 1'b0;
        be_q    <= '1;
        wdata_q <= '0;
      end else begin
        addr_q  <= bus.dm_addr;
        we_q    <= bus.dm_we;
        be_q    <= bus.dm_be;
        wdata_q <= bus.dm_wdata;
      end
    end
  end

  // Capture completion data for the owner only; stores report zero
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if ((state == WAIT) && bus.mem_rvalid) begin
      if (owner == REQ_IF) begin
        if_rdata_q <= we_q ? '0 : bus.mem_rdata;
      end else begin
        dm_rdata_q <= we_q ? '0 : bus.mem_rdata;
      end
    end
  end

  // Sticky flag for completions that arrive with nothing outstanding
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.mem_rvalid && (state != WAIT)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.if_req_ready  = if_ready;
  assign bus.dm_req_ready  = dm_ready;
  assign bus.if_resp_valid = if_rvalid;
  assign bus.dm_resp_valid = dm_rvalid;
  assign bus.if_resp_rdata = if_rdata_q;
  assign bus.dm_resp_rdata = dm_rdata_q;
  assign bus.mem_req       = mem_strobe;
  assign bus.mem_we        = we_q;
  assign bus.mem_be        = be_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign err_spurious      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_memory_arbiter
// Description : Self-checking bench: requester and memory agents plus a
//               transaction-level timing model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_memory_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_spurious;

  unified_memory_arbiter_if #(.AddrSize(32), .DataSize(32)) bus ();

  unified_memory_arbiter #(.AddrSize(32), .DataSize(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Requester agents
  bit          if_pend, dm_pend;
  logic [31:0] if_a, dm_a, dm_wd;
  logic        dm_w;
  logic [3:0]  dm_b;
  int          if_prob, dm_prob;
  // Memory agent
  logic [31:0] mem [logic [31:0]];
  bit          m_busy, inject;
  int          m_cnt, lat_min, lat_max;
  logic [31:0] m_a, m_wd;
  logic        m_w;
  logic [3:0]  m_b;
  // Transaction model
  typedef struct {
    int owner; logic [31:0] addr; logic we; logic [3:0] be;
    logic [31:0] wdata; int acc; int done; logic [31:0] rdata;
  } txn_t;
  txn_t        t;
  bit          have_txn, exp_err;
  int          last_gnt;
  logic [31:0] last_rd [2];
  // Event logs
  int gnt_log[$]; int gnt_cyc[$];
  int resp_who[$]; int resp_cyc[$]; logic [31:0] resp_dat[$];
  int mreq_cyc[$]; logic [31:0] mreq_addr[$]; logic mreq_we[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B1) ^ 32'h0BAD_F00D);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(15)) << 2;
  endfunction

  task automatic clear_logs();
    gnt_log.delete(); gnt_cyc.delete(); resp_who.delete(); resp_cyc.delete();
    resp_dat.delete(); mreq_cyc.delete(); mreq_addr.delete(); mreq_we.delete();
    cyc = 0;
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, check, advance model
  task automatic step(input bit checking);
    logic        rv;
    logic [31:0] rd;
    logic [1:0]  vld, exp_rdy;
    int          exp_owner;
    bit          resp_now;
    @(negedge clk);
    if (!if_pend && ($urandom_range(99) < 32'(if_prob))) begin
      if_pend = 1'b1; if_a = rand_addr();
    end
    if (!dm_pend && ($urandom_range(99) < 32'(dm_prob))) begin
      dm_pend = 1'b1; dm_a = rand_addr(); dm_w = 1'($urandom_range(1));
      dm_b = 4'($urandom_range(15)); dm_wd = $urandom;
    end
    bus.if_req_valid = if_pend; bus.if_addr = if_a;
    bus.dm_req_valid = dm_pend; bus.dm_addr = dm_a; bus.dm_we = dm_w;
    bus.dm_be = dm_b; bus.dm_wdata = dm_wd;
    rv = inject; rd = $urandom; inject = 1'b0;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        rv = 1'b1; m_busy = 1'b0;
        if (m_w) mem[m_a] = merge(mem_rd(m_a), m_wd, m_b);
        else rd = mem_rd(m_a);
      end
    end
    bus.mem_rvalid = rv; bus.mem_rdata = rd;
    #1;
    exp_rdy = 2'b00; exp_owner = 0;
    if (checking) begin
      vld = {dm_pend, if_pend};
      if (!have_txn && vld != 2'b00) begin
        exp_owner = (vld == 2'b11) ? (1 - last_gnt) : (vld[1] ? 1 : 0);
        exp_rdy[exp_owner] = 1'b1;
      end
      chk("if_req_ready", bus.if_req_ready, exp_rdy[0]);
      chk("dm_req_ready", bus.dm_req_ready, exp_rdy[1]);
      chk("mem_req", bus.mem_req, have_txn && cyc == t.acc + 1);
      if (have_txn && cyc >= t.acc + 1 && t.done < 0) begin
        chk("mem_addr", bus.mem_addr, t.addr);
        chk("mem_we", bus.mem_we, t.we);
        chk("mem_be", bus.mem_be, t.be);
        if (t.we) chk("mem_wdata", bus.mem_wdata, t.wdata);
      end
      resp_now = have_txn && t.done >= 0 && cyc == t.done + 1;
      chk("if_resp_valid", bus.if_resp_valid, resp_now && t.owner == 0);
      chk("dm_resp_valid", bus.dm_resp_valid, resp_now && t.owner == 1);
      if (resp_now && t.owner == 0) chk("if_resp_rdata", bus.if_resp_rdata, t.rdata);
      else chk("if_rdata_hold", bus.if_resp_rdata, last_rd[0]);
      if (resp_now && t.owner == 1) chk("dm_resp_rdata", bus.dm_resp_rdata, t.rdata);
      else chk("dm_rdata_hold", bus.dm_resp_rdata, last_rd[1]);
      chk("err_spurious", err_spurious, exp_err);
      // Model advance
      if (rv) begin
        if (have_txn && t.done < 0 && cyc >= t.acc + 2) begin
          t.done = cyc; t.rdata = t.we ? 32'h0 : rd;
        end else exp_err = 1'b1;
      end
      if (resp_now) begin
        last_rd[t.owner] = t.rdata; have_txn = 1'b0;
        resp_who.push_back(t.owner); resp_cyc.push_back(cyc); resp_dat.push_back(t.rdata);
      end
      if (exp_rdy != 2'b00) begin
        t.owner = exp_owner; t.acc = cyc; t.done = -1;
        if (exp_owner == 0) begin
          t.addr = if_a; t.we = 1'b0; t.be = 4'hF; t.wdata = 32'h0;
        end else begin
          t.addr = dm_a; t.we = dm_w; t.be = dm_b; t.wdata = dm_wd;
        end
        have_txn = 1'b1; last_gnt = exp_owner;
        gnt_log.push_back(exp_owner); gnt_cyc.push_back(cyc);
      end
    end
    // Agents react to the DUT's actual handshakes
    if (bus.mem_req) begin
      m_busy = 1'b1; m_cnt = int'($urandom_range(lat_max, lat_min));
      m_a = bus.mem_addr; m_w = bus.mem_we; m_b = bus.mem_be; m_wd = bus.mem_wdata;
      mreq_cyc.push_back(cyc); mreq_addr.push_back(bus.mem_addr); mreq_we.push_back(bus.mem_we);
    end
    if (bus.if_req_ready && if_pend) if_pend = 1'b0;
    if (bus.dm_req_ready && dm_pend) dm_pend = 1'b0;
    cyc++;
  endtask

  task automatic do_reset(input bit keep_mem);
    rst = 1'b1; if_pend = 1'b0; dm_pend = 1'b0; if_prob = 0; dm_prob = 0; inject = 1'b0;
    if (!keep_mem) m_busy = 1'b0;
    step(1'b0); step(1'b0);
    rst = 1'b0;
    have_txn = 1'b0; exp_err = 1'b0; last_gnt = 1; last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    clear_logs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  initial begin
    bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.dm_req_valid = 1'b0; bus.dm_we = 1'b0;
    bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    if_a = '0; dm_a = '0; dm_wd = '0; dm_w = 1'b0; dm_b = '0; lat_min = 1; lat_max = 1;

    // Reset state
    do_reset(1'b0);
    run(1);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_be", bus.mem_be, 4'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);

    // IF-only read, latency 1
    mem[32'h10] = 32'h0000_0013;
    do_reset(1'b0);
    if_pend = 1'b1; if_a = 32'h10; lat_min = 1; lat_max = 1;
    run(8);
    chk("t1_grants", gnt_log.size(), 1);
    chk("t1_resps", resp_who.size(), 1);
    if (gnt_cyc.size() == 1 && mreq_cyc.size() == 1 && resp_cyc.size() == 1) begin
      chk("t1_mreq_cycle", mreq_cyc[0] - gnt_cyc[0], 1);
      chk("t1_mreq_addr", mreq_addr[0], 32'h10);
      chk("t1_mreq_we", mreq_we[0], 1'b0);
      chk("t1_resp_cycle", resp_cyc[0] - gnt_cyc[0], 3);
      chk("t1_resp_who", resp_who[0], 0);
      chk("t1_resp_data", resp_dat[0], 32'h0000_0013);
    end

    // Simultaneous IF and DM load from reset
    do_reset(1'b0);
    if_pend = 1'b1; if_a = 32'h100;
    dm_pend = 1'b1; dm_a = 32'h2000; dm_w = 1'b0; dm_b = 4'hF; dm_wd = 32'h0;
    lat_min = 1; lat_max = 3;
    run(16);
    chk("t2_resps", resp_who.size(), 2);
    if (resp_who.size() == 2) begin
      chk("t2_first_if", resp_who[0], 0);
      chk("t2_second_dm", resp_who[1], 1);
      chk("t2_if_data", resp_dat[0], mem_rd(32'h100));
      chk("t2_dm_data", resp_dat[1], mem_rd(32'h2000));
      chk("t2_no_overlap", resp_cyc[1] > resp_cyc[0] + 3, 1'b1);
    end

    // Continuous contention: eight alternating grants
    do_reset(1'b0);
    if_prob = 100; dm_prob = 100; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 200 && gnt_log.size() < 8; i++) step(1'b1);
    chk("t3_reached_8", gnt_log.size() >= 8, 1'b1);
    if (gnt_log.size() >= 8) begin
      int n_if;
      n_if = 0;
      for (int i = 0; i < 8; i++) begin
        chk("t3_alternate", gnt_log[i], i % 2);
        if (gnt_log[i] == 0) n_if++;
      end
      chk("t3_if_count", n_if, 4);
    end
    if_prob = 0; dm_prob = 0;
    run(30);

    // DM store, latency 5
    mem[32'h40] = 32'h1122_3344;
    do_reset(1'b0);
    dm_pend = 1'b1; dm_a = 32'h40; dm_w = 1'b1; dm_b = 4'b0011; dm_wd = 32'hDEAD_BEEF;
    lat_min = 5; lat_max = 5;
    run(12);
    chk("t4_resps", resp_who.size(), 1);
    if (resp_who.size() == 1 && gnt_cyc.size() == 1) begin
      chk("t4_resp_who", resp_who[0], 1);
      chk("t4_resp_data", resp_dat[0], 32'h0);
      chk("t4_resp_cycle", resp_cyc[0] - gnt_cyc[0], 7);
    end
    chk("t4_mem_word", mem_rd(32'h40), 32'h1122_BEEF);

    // Spurious completion while idle, then a normal read
    do_reset(1'b0);
    inject = 1'b1;
    run(4);
    chk("t5_err_set", err_spurious, 1'b1);
    chk("t5_no_resp", resp_who.size(), 0);
    if_pend = 1'b1; if_a = 32'h10; lat_min = 1; lat_max = 3;
    run(10);
    chk("t5_err_sticky", err_spurious, 1'b1);
    chk("t5_resps", resp_who.size(), 1);
    if (resp_who.size() == 1) chk("t5_resp_data", resp_dat[0], 32'h0000_0013);

    // Reset while waiting on memory, then a late completion
    do_reset(1'b0);
    if_pend = 1'b1; if_a = 32'h300; lat_min = 8; lat_max = 8;
    run(3);
    do_reset(1'b1);
    run(8);
    chk("t6_err_late", err_spurious, 1'b1);
    chk("t6_no_resp", resp_who.size(), 0);
    if_pend = 1'b1; if_a = 32'h304; lat_min = 2; lat_max = 2;
    run(8);
    chk("t6_resps", resp_who.size(), 1);
    if (resp_who.size() == 1) begin
      chk("t6_resp_who", resp_who[0], 0);
      chk("t6_resp_data", resp_dat[0], mem_rd(32'h304));
    end

    // Randomised mixed traffic
    do_reset(1'b0);
    if_prob = 40; dm_prob = 40; lat_min = 1; lat_max = 5;
    run(400);
    if_prob = 0; dm_prob = 0;
    run(40);
    chk("t7_all_answered", resp_who.size(), gnt_log.size());
    chk("t7_traffic", gnt_log.size() > 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
